// File: rtl/bomb_pkg.sv
// Shared encodings for the bomb controller: register ctrl codes and FSM state codes.
package bomb_pkg;

   localparam logic [1:0] REG_NONE = 2'd0;
   localparam logic [1:0] REG_INCR = 2'd1;
   localparam logic [1:0] REG_LOAD = 2'd2;
   localparam logic [1:0] REG_CLR  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARMED    = 3'd1,
      ST_CHECK    = 3'd2,
      ST_DEFUSED  = 3'd3,
      ST_EXPLODED = 3'd4
   } state_t;

   function automatic logic is_terminal(input state_t s);
      return (s == ST_DEFUSED) || (s == ST_EXPLODED);
   endfunction

endpackage

// File: rtl/bomb_timer.sv
// Loadable saturating countdown with tick decrement and zero-crossing flag.
// Macro BOMB_PENALTY_EN adds a second decrement source that removes PENALTY at once.
module bomb_timer #(
   parameter int unsigned TIME_W  = 8
`ifdef BOMB_PENALTY_EN
   , parameter int unsigned PENALTY = 10
`endif
) (
   input  logic              clk,
   input  logic              async_nreset,
   input  logic              load,
   input  logic [TIME_W-1:0] load_val,
   input  logic              dec,
`ifdef BOMB_PENALTY_EN
   input  logic              pen,
`endif
   output logic [TIME_W-1:0] time_left,
   output logic              expire
);

   logic [TIME_W-1:0] next_time;
   logic              active;

`ifdef BOMB_PENALTY_EN
   logic [TIME_W+1:0] amount;

   always_comb begin
      amount = (TIME_W+2)'(dec) + (pen ? (TIME_W+2)'(PENALTY) : '0);
      active = dec | pen;
      if (amount >= (TIME_W+2)'(time_left))
         next_time = '0;
      else
         next_time = time_left - amount[TIME_W-1:0];
   end
`else
   always_comb begin
      active    = dec;
      next_time = (dec && (time_left != '0)) ? time_left - TIME_W'(1) : time_left;
   end
`endif

   // Expiry means a decrement landed on zero in this cycle.
   assign expire = active && (next_time == '0);

   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset)
         time_left <= '0;
      else if (load)
         time_left <= load_val;
      else if (active)
         time_left <= next_time;
   end

endmodule

// File: rtl/bomb_ctrl_fsm.sv
// Bomb controller FSM: drives external idx/att register ctrls, owns countdown and code buffer.
// Macro BOMB_PENALTY_EN enables the wrong-code time penalty.
module bomb_ctrl_fsm
   import bomb_pkg::*;
#(
   parameter int unsigned DIGITS       = 4,
   parameter int unsigned TIME_W       = 8,
   parameter int unsigned ARM_TIME     = 60,
   parameter int unsigned MAX_ATTEMPTS = 3,
   parameter int unsigned IDX_W        = 3,
   parameter int unsigned ATT_W        = 2,
   parameter int unsigned PENALTY      = 10
) (
   input  logic                  clk,
   input  logic                  async_nreset,
   input  logic                  arm,
   input  logic                  tick,
   input  logic                  key_valid,
   input  logic [3:0]            key_digit,
   input  logic [4*DIGITS-1:0]   secret,
   input  logic [IDX_W-1:0]      idx_q,
   input  logic [ATT_W-1:0]      att_q,
   output logic [1:0]            idx_ctrl,
   output logic [1:0]            att_ctrl,
   output logic [TIME_W-1:0]     time_left,
   output logic [2:0]            state,
   output logic                  defused,
   output logic                  exploded
);

   if (DIGITS < 2 || DIGITS - 1 >= (1 << IDX_W)) begin : g_bad_digits
      $error("bomb_ctrl_fsm: DIGITS out of range for IDX_W");
   end
   if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS - 1 >= (1 << ATT_W)) begin : g_bad_att
      $error("bomb_ctrl_fsm: MAX_ATTEMPTS out of range for ATT_W");
   end
   if (ARM_TIME >= (1 << TIME_W) || PENALTY >= (1 << TIME_W)) begin : g_bad_time
      $error("bomb_ctrl_fsm: ARM_TIME or PENALTY does not fit TIME_W");
   end

   state_t              st;
   logic [4*DIGITS-1:0] entry;
   logic                match;
   logic                last_digit;
   logic                last_attempt;
   logic                timer_load;
   logic                timer_dec;
   logic                expire;

   assign match        = (entry == secret);
   assign last_digit   = (idx_q == IDX_W'(DIGITS - 1));
   assign last_attempt = (att_q == ATT_W'(MAX_ATTEMPTS - 1));
   assign timer_load   = (st == ST_IDLE) && arm;
   assign timer_dec    = tick && ((st == ST_ARMED) || (st == ST_CHECK));
   assign state        = st;

   bomb_timer #(
      .TIME_W   (TIME_W)
`ifdef BOMB_PENALTY_EN
      , .PENALTY(PENALTY)
`endif
   ) u_timer (
      .clk          (clk),
      .async_nreset (async_nreset),
      .load         (timer_load),
      .load_val     (TIME_W'(ARM_TIME)),
      .dec          (timer_dec),
`ifdef BOMB_PENALTY_EN
      .pen          ((st == ST_CHECK) && !match),
`endif
      .time_left    (time_left),
      .expire       (expire)
   );

   always_comb begin
      idx_ctrl = REG_NONE;
      att_ctrl = REG_NONE;
      case (st)
         ST_IDLE: begin
            idx_ctrl = REG_CLR;
            att_ctrl = REG_CLR;
         end
         ST_ARMED: begin
            if (key_valid)
               idx_ctrl = REG_INCR;
         end
         ST_CHECK: begin
            if (!match) begin
               idx_ctrl = REG_CLR;
               att_ctrl = REG_INCR;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
         st       <= ST_IDLE;
         entry    <= '0;
         defused  <= 1'b0;
         exploded <= 1'b0;
      end else begin
         case (st)
            ST_IDLE: begin
               if (arm) begin
                  st    <= ST_ARMED;
                  entry <= '0;
               end
            end
            ST_ARMED: begin
               if (key_valid)
                  entry <= {entry[4*DIGITS-5:0], key_digit};
               // Expiry outranks the move to CHECK on the final digit.
               if (expire) begin
                  st       <= ST_EXPLODED;
                  exploded <= 1'b1;
               end else if (key_valid && last_digit) begin
                  st <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (expire || (!match && last_attempt)) begin
                  st       <= ST_EXPLODED;
                  exploded <= 1'b1;
               end else if (match) begin
                  st      <= ST_DEFUSED;
                  defused <= 1'b1;
               end else begin
                  st    <= ST_ARMED;
                  entry <= '0;
               end
            end
            default: begin
               if (!is_terminal(st))
                  st <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
